// File: rtl/vx_tensor_d_writeback_pkg.sv
// Shared tensor definitions: tile geometry, fp32 element and tile types,
// plus the writeback FSM state encoding.
package vx_tensor_d_writeback_pkg;

   localparam int unsigned TILE_M       = 4;
   localparam int unsigned TILE_N       = 4;
   localparam int unsigned TILE_ELEMS   = TILE_M * TILE_N;
   localparam int unsigned NW_WIDTH_DEF = 4;

   typedef logic [31:0] fp32_t;
   typedef fp32_t [TILE_M-1:0][TILE_N-1:0] tile_t;

   typedef enum logic {
      WB_IDLE,
      WB_DRAIN
   } wb_state_e;

   function automatic int unsigned beat_w(input int unsigned num_beats);
      return (num_beats <= 1) ? 1 : $clog2(num_beats);
   endfunction

endpackage

// File: rtl/vx_tensor_d_writeback_beat_counter.sv
// Modulo-NUM_BEATS beat counter; clr has priority over en and restarts at 0.
module vx_tensor_beat_counter #(
   parameter int unsigned NUM_BEATS = 2,
   parameter int unsigned W         = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         last
);

   assign last = (cnt == W'(NUM_BEATS - 1));

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= last ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vx_tensor_d_writeback.sv
// Tensor D tile writeback: holds one 4x4 fp32 tile and serializes it into
// LANES-wide commit beats, accepting the next tile on the last beat's fire.
module vx_tensor_d_writeback
   import vx_tensor_d_writeback_pkg::*;
#(
   parameter int unsigned LANES         = 8,
   parameter int unsigned RD_WIDTH      = 5,
   parameter int unsigned PERF_CTR_BITS = 32,
   parameter int unsigned NW_WIDTH      = NW_WIDTH_DEF,
   localparam int unsigned NUM_BEATS    = TILE_ELEMS / LANES,
   localparam int unsigned BEAT_W       = beat_w(NUM_BEATS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         valid_in,
   output logic                         ready_in,
   input  tile_t                        D_tile,
   input  logic [NW_WIDTH-1:0]          D_wid,
   input  logic [RD_WIDTH-1:0]          D_rd,
   output logic                         valid_out,
   input  logic                         ready_out,
   output logic [LANES-1:0][31:0]       data_out,
   output logic [NW_WIDTH-1:0]          wid_out,
   output logic [RD_WIDTH-1:0]          rd_out,
   output logic [BEAT_W-1:0]            beat_out,
   output logic                         eop_out,
   output logic                         busy,
   output logic [PERF_CTR_BITS-1:0]     perf_stall_cnt
);

   if (!(LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("vx_tensor_d_writeback: LANES must be 4, 8 or 16");
   end

   wb_state_e                       state_q, state_d;
   tile_t                           tile_q;
   logic [TILE_ELEMS-1:0][31:0]     elems;
   logic [NW_WIDTH-1:0]             wid_q;
   logic [RD_WIDTH-1:0]             rd_q;
   logic [BEAT_W-1:0]               beat_q;
   logic                            beat_last;
   logic                            fire_in;
   logic                            fire_out;

   assign valid_out = (state_q == WB_DRAIN);
   assign busy      = valid_out;
   assign eop_out   = valid_out && beat_last;
   assign fire_out  = valid_out && ready_out;
   // Combinational ready_out -> ready_in path keeps back-to-back tiles bubble-free.
   assign ready_in  = (state_q == WB_IDLE) || (fire_out && eop_out);
   assign fire_in   = valid_in && ready_in;

   vx_tensor_beat_counter #(
      .NUM_BEATS (NUM_BEATS),
      .W         (BEAT_W)
   ) u_beat_counter (
      .clk   (clk),
      .reset (reset),
      .en    (fire_out),
      .clr   (fire_in),
      .cnt   (beat_q),
      .last  (beat_last)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         WB_IDLE:  if (fire_in) state_d = WB_DRAIN;
         WB_DRAIN: if (fire_out && beat_last) state_d = fire_in ? WB_DRAIN : WB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= WB_IDLE;
         tile_q         <= '0;
         wid_q          <= '0;
         rd_q           <= '0;
         perf_stall_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (fire_in) begin
            tile_q <= D_tile;
            wid_q  <= D_wid;
            rd_q   <= D_rd;
         end
         if (valid_out && !ready_out) begin
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
         end
      end
   end

   // Packed [row][col] layout already places elem[r*4+c] at index r*4+c.
   assign elems = tile_q;

   always_comb begin
      data_out = '0;
      for (int unsigned j = 0; j < LANES; j++) begin
         data_out[j] = elems[4'(32'(beat_q) * LANES + j)];
      end
   end

   assign wid_out  = wid_q;
   assign rd_out   = rd_q + RD_WIDTH'(beat_q);
   assign beat_out = beat_q;

   a_no_fire_mid_drain: assert property (@(posedge clk) disable iff (reset)
      !(fire_in && (state_q == WB_DRAIN) && !(fire_out && beat_last)));

endmodule

// File: tb/tb_vx_tensor_d_writeback.sv
// Scoreboard bench for vx_tensor_d_writeback at LANES = 4, 8 and 16.
module tb_vx_tensor_d_writeback;
   import vx_tensor_d_writeback_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [15:0][31:0] data;
      logic [3:0]        wid;
      logic [4:0]        rd;
      logic [1:0]        beat;
      logic              eop;
   } exp_t;
   exp_t sb[$];

   // LANES = 4
   logic valid_in_4, ready_in_4, valid_out_4, ready_out_4, eop_4, busy_4;
   tile_t tile_4; logic [3:0] wid_4, wid_out_4; logic [4:0] rd_4, rd_out_4;
   logic [3:0][31:0] data_4; logic [1:0] beat_4; logic [31:0] stall_4;
   // LANES = 8
   logic valid_in_8, ready_in_8, valid_out_8, ready_out_8, eop_8, busy_8;
   tile_t tile_8; logic [3:0] wid_8, wid_out_8; logic [4:0] rd_8, rd_out_8;
   logic [7:0][31:0] data_8; logic [0:0] beat_8; logic [31:0] stall_8;
   // LANES = 16
   logic valid_in_16, ready_in_16, valid_out_16, ready_out_16, eop_16, busy_16;
   tile_t tile_16; logic [3:0] wid_16, wid_out_16; logic [4:0] rd_16, rd_out_16;
   logic [15:0][31:0] data_16; logic [0:0] beat_16; logic [31:0] stall_16;

   vx_tensor_d_writeback #(.LANES(4), .RD_WIDTH(5), .PERF_CTR_BITS(32), .NW_WIDTH(4)) u_wb4 (
      .clk(clk), .reset(reset), .valid_in(valid_in_4), .ready_in(ready_in_4),
      .D_tile(tile_4), .D_wid(wid_4), .D_rd(rd_4), .valid_out(valid_out_4),
      .ready_out(ready_out_4), .data_out(data_4), .wid_out(wid_out_4), .rd_out(rd_out_4),
      .beat_out(beat_4), .eop_out(eop_4), .busy(busy_4), .perf_stall_cnt(stall_4));

   vx_tensor_d_writeback #(.LANES(8), .RD_WIDTH(5), .PERF_CTR_BITS(32), .NW_WIDTH(4)) u_wb8 (
      .clk(clk), .reset(reset), .valid_in(valid_in_8), .ready_in(ready_in_8),
      .D_tile(tile_8), .D_wid(wid_8), .D_rd(rd_8), .valid_out(valid_out_8),
      .ready_out(ready_out_8), .data_out(data_8), .wid_out(wid_out_8), .rd_out(rd_out_8),
      .beat_out(beat_8), .eop_out(eop_8), .busy(busy_8), .perf_stall_cnt(stall_8));

   vx_tensor_d_writeback #(.LANES(16), .RD_WIDTH(5), .PERF_CTR_BITS(32), .NW_WIDTH(4)) u_wb16 (
      .clk(clk), .reset(reset), .valid_in(valid_in_16), .ready_in(ready_in_16),
      .D_tile(tile_16), .D_wid(wid_16), .D_rd(rd_16), .valid_out(valid_out_16),
      .ready_out(ready_out_16), .data_out(data_16), .wid_out(wid_out_16), .rd_out(rd_out_16),
      .beat_out(beat_16), .eop_out(eop_16), .busy(busy_16), .perf_stall_cnt(stall_16));

   function automatic tile_t to_tile(input logic [15:0][31:0] f);
      tile_t t;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            t[r][c] = f[r*4 + c];
      return t;
   endfunction

   function automatic void push_beats(input int lanes, input logic [15:0][31:0] f,
                                      input logic [3:0] wid, input int rd);
      exp_t e;
      int nb = 16 / lanes;
      for (int k = 0; k < nb; k++) begin
         e.data = '0;
         for (int j = 0; j < lanes; j++) e.data[j] = f[k*lanes + j];
         e.wid  = wid;
         e.rd   = 5'((rd + k) % 32);
         e.beat = 2'(k);
         e.eop  = (k == nb - 1);
         sb.push_back(e);
      end
   endfunction

   task automatic test_reset();
      n_tests++;
      if ({valid_out_4, valid_out_8, valid_out_16, busy_4, busy_8, busy_16,
           eop_4, eop_8, eop_16} !== 9'b0) begin
         n_fail++; $display("FAIL reset_ctrl valid/busy/eop=%b required 0",
            {valid_out_4, valid_out_8, valid_out_16, busy_4, busy_8, busy_16, eop_4, eop_8, eop_16});
      end
      n_tests++;
      if ({ready_in_4, ready_in_8, ready_in_16} !== 3'b111) begin
         n_fail++; $display("FAIL reset_ready ready_in=%b required 111", {ready_in_4, ready_in_8, ready_in_16});
      end
      n_tests++;
      if (data_8 !== '0 || rd_out_8 !== 5'd0 || wid_out_8 !== 4'd0 || beat_8 !== 1'b0 ||
          beat_4 !== 2'd0 || data_4 !== '0 || data_16 !== '0) begin
         n_fail++; $display("FAIL reset_payload data8=%h rd=%0d wid=%0d beat=%0d required 0",
            data_8, rd_out_8, wid_out_8, beat_8);
      end
      n_tests++;
      if (stall_4 !== 0 || stall_8 !== 0 || stall_16 !== 0) begin
         n_fail++; $display("FAIL reset_stall cnt=%0d/%0d/%0d required 0", stall_4, stall_8, stall_16);
      end
   endtask

   task automatic test_single_tile();
      logic [15:0][31:0] f;
      exp_t e;
      for (int i = 0; i < 16; i++) f[i] = 32'h100 + i;
      sb.delete();
      push_beats(8, f, 4'd3, 10);
      @(negedge clk);
      tile_8 = to_tile(f); wid_8 = 4'd3; rd_8 = 5'd10; valid_in_8 = 1'b1; ready_out_8 = 1'b1;
      #1;
      n_tests++;
      if (ready_in_8 !== 1'b1) begin n_fail++; $display("FAIL single_accept ready_in=%b required 1", ready_in_8); end
      @(negedge clk); valid_in_8 = 1'b0; #1;
      n_tests++;
      if (valid_out_8 !== 1'b1) begin n_fail++; $display("FAIL single_latency valid_out=%b required 1", valid_out_8); end
      for (int c = 0; c < 6 && sb.size() > 0; c++) begin
         if (valid_out_8 && ready_out_8) begin
            e = sb.pop_front();
            n_tests++;
            if (data_8 !== e.data[7:0] || rd_out_8 !== e.rd || wid_out_8 !== e.wid ||
                {1'b0, beat_8} !== e.beat || eop_8 !== e.eop) begin
               n_fail++; $display("FAIL single_beat data=%h rd=%0d wid=%0d beat=%0d eop=%b required data=%h rd=%0d wid=%0d beat=%0d eop=%b",
                  data_8, rd_out_8, wid_out_8, beat_8, eop_8, e.data[7:0], e.rd, e.wid, e.beat, e.eop);
            end
         end
         @(negedge clk); #1;
      end
      n_tests++;
      if (sb.size() != 0 || valid_out_8 !== 1'b0) begin
         n_fail++; $display("FAIL single_drain pending=%0d valid_out=%b required 0/0", sb.size(), valid_out_8);
      end
   endtask

   task automatic test_stall();
      logic [15:0][31:0] f;
      logic [31:0] s0;
      exp_t e;
      for (int i = 0; i < 16; i++) f[i] = 32'h400 + i;
      sb.delete();
      push_beats(8, f, 4'd5, 7);
      s0 = stall_8;
      @(negedge clk);
      tile_8 = to_tile(f); wid_8 = 4'd5; rd_8 = 5'd7; valid_in_8 = 1'b1; ready_out_8 = 1'b0;
      #1;
      n_tests++;
      if (ready_in_8 !== 1'b1) begin n_fail++; $display("FAIL stall_accept ready_in=%b required 1", ready_in_8); end
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk); valid_in_8 = 1'b1; #1;
         n_tests++;
         if (valid_out_8 !== 1'b1 || beat_8 !== 1'b0 || data_8 !== sb[0].data[7:0] ||
             rd_out_8 !== 5'd7 || ready_in_8 !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold cyc=%0d valid=%b beat=%0d data=%h rd=%0d ready_in=%b required 1/0/%h/7/0",
               c, valid_out_8, beat_8, data_8, rd_out_8, ready_in_8, sb[0].data[7:0]);
         end
      end
      @(negedge clk); valid_in_8 = 1'b0; ready_out_8 = 1'b1; #1;
      n_tests++;
      if (stall_8 - s0 !== 32'd5) begin n_fail++; $display("FAIL stall_count got=%0d required 5", stall_8 - s0); end
      for (int c = 0; c < 2; c++) begin
         e = sb.pop_front();
         n_tests++;
         if (valid_out_8 !== 1'b1 || data_8 !== e.data[7:0] || rd_out_8 !== e.rd ||
             {1'b0, beat_8} !== e.beat || eop_8 !== e.eop) begin
            n_fail++; $display("FAIL stall_beat valid=%b data=%h rd=%0d beat=%0d eop=%b required 1/%h/%0d/%0d/%b",
               valid_out_8, data_8, rd_out_8, beat_8, eop_8, e.data[7:0], e.rd, e.beat, e.eop);
         end
         @(negedge clk); #1;
      end
      n_tests++;
      if (stall_8 - s0 !== 32'd5 || valid_out_8 !== 1'b0) begin
         n_fail++; $display("FAIL stall_final cnt=%0d valid=%b required 5/0", stall_8 - s0, valid_out_8);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0][31:0] fa, fb;
      logic exp_ri, exp_vo;
      exp_t e;
      for (int i = 0; i < 16; i++) begin fa[i] = 32'h200 + i; fb[i] = 32'h300 + i; end
      sb.delete();
      push_beats(4, fa, 4'd1, 0);
      push_beats(4, fb, 4'd2, 0);
      for (int c = 0; c <= 9; c++) begin
         @(negedge clk);
         valid_in_4  = (c <= 4);
         tile_4      = (c == 0) ? to_tile(fa) : to_tile(fb);
         wid_4       = (c == 0) ? 4'd1 : 4'd2;
         rd_4        = 5'd0;
         ready_out_4 = 1'b1;
         #1;
         exp_ri = (c == 0 || c == 4 || c == 8 || c == 9);
         exp_vo = (c >= 1 && c <= 8);
         n_tests++;
         if (ready_in_4 !== exp_ri || valid_out_4 !== exp_vo) begin
            n_fail++; $display("FAIL b2b_handshake cyc=%0d ready_in=%b valid_out=%b required %b/%b",
               c, ready_in_4, valid_out_4, exp_ri, exp_vo);
         end
         if (valid_out_4 && ready_out_4) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL b2b_extra_beat cyc=%0d got beat with empty scoreboard", c);
            end else begin
               e = sb.pop_front();
               if (data_4 !== e.data[3:0] || rd_out_4 !== e.rd || wid_out_4 !== e.wid ||
                   beat_4 !== e.beat || eop_4 !== e.eop) begin
                  n_fail++; $display("FAIL b2b_beat cyc=%0d data=%h rd=%0d wid=%0d beat=%0d eop=%b required %h/%0d/%0d/%0d/%b",
                     c, data_4, rd_out_4, wid_out_4, beat_4, eop_4, e.data[3:0], e.rd, e.wid, e.beat, e.eop);
               end
            end
         end
      end
      valid_in_4 = 1'b0;
      n_tests++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain pending=%0d required 0", sb.size()); end
   endtask

   task automatic test_rd_wrap();
      logic [15:0][31:0] f;
      exp_t e;
      for (int i = 0; i < 16; i++) f[i] = 32'h500 + i;
      sb.delete();
      push_beats(4, f, 4'd7, 31);
      @(negedge clk);
      tile_4 = to_tile(f); wid_4 = 4'd7; rd_4 = 5'd31; valid_in_4 = 1'b1; ready_out_4 = 1'b1;
      @(negedge clk); valid_in_4 = 1'b0; #1;
      for (int c = 0; c < 8 && sb.size() > 0; c++) begin
         if (valid_out_4 && ready_out_4) begin
            e = sb.pop_front();
            n_tests++;
            if (rd_out_4 !== e.rd || data_4 !== e.data[3:0] || beat_4 !== e.beat || eop_4 !== e.eop) begin
               n_fail++; $display("FAIL rd_wrap rd=%0d data=%h beat=%0d eop=%b required %0d/%h/%0d/%b",
                  rd_out_4, data_4, beat_4, eop_4, e.rd, e.data[3:0], e.beat, e.eop);
            end
         end
         @(negedge clk); #1;
      end
      n_tests++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL rd_wrap_drain pending=%0d required 0", sb.size()); end
   endtask

   task automatic test_single_beat();
      logic [15:0][31:0] f;
      exp_t e;
      for (int i = 0; i < 16; i++) f[i] = 32'h600 + i;
      sb.delete();
      push_beats(16, f, 4'd9, 20);
      @(negedge clk);
      tile_16 = to_tile(f); wid_16 = 4'd9; rd_16 = 5'd20; valid_in_16 = 1'b1; ready_out_16 = 1'b1;
      @(negedge clk); valid_in_16 = 1'b0; #1;
      e = sb.pop_front();
      n_tests++;
      if (valid_out_16 !== 1'b1 || data_16 !== e.data || rd_out_16 !== 5'd20 || wid_out_16 !== 4'd9 ||
          beat_16 !== 1'b0 || eop_16 !== 1'b1 || ready_in_16 !== 1'b1) begin
         n_fail++; $display("FAIL single_beat16 valid=%b data=%h rd=%0d wid=%0d beat=%0d eop=%b ready_in=%b required 1/%h/20/9/0/1/1",
            valid_out_16, data_16, rd_out_16, wid_out_16, beat_16, eop_16, ready_in_16, e.data);
      end
      @(negedge clk); #1;
      n_tests++;
      if (valid_out_16 !== 1'b0) begin n_fail++; $display("FAIL single_beat16_idle valid=%b required 0", valid_out_16); end
   endtask

   task automatic test_random_stress();
      logic [15:0][31:0] f;
      logic [3:0] w;
      int rd;
      logic have_tile, exp_ri, exp_vo, accepted;
      exp_t e;
      sb.delete();
      have_tile = 1'b0;
      accepted  = 1'b0;
      valid_in_16 = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         if (accepted) begin valid_in_16 = 1'b0; accepted = 1'b0; end
         if (!have_tile && $urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 16; i++) f[i] = $urandom;
            w  = 4'($urandom_range(0, 15));
            rd = $urandom_range(0, 31);
            tile_16 = to_tile(f); wid_16 = w; rd_16 = 5'(rd);
            valid_in_16 = 1'b1;
            have_tile   = 1'b1;
         end
         ready_out_16 = ($urandom_range(0, 3) != 0);
         #1;
         exp_vo = (sb.size() != 0);
         exp_ri = (sb.size() == 0) || ready_out_16;
         n_tests++;
         if (valid_out_16 !== exp_vo || ready_in_16 !== exp_ri) begin
            n_fail++; $display("FAIL stress_handshake cyc=%0d valid_out=%b ready_in=%b required %b/%b",
               cyc, valid_out_16, ready_in_16, exp_vo, exp_ri);
         end
         if (valid_out_16 && ready_out_16 && sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (data_16 !== e.data || rd_out_16 !== e.rd || wid_out_16 !== e.wid ||
                beat_16 !== 1'b0 || eop_16 !== 1'b1) begin
               n_fail++; $display("FAIL stress_beat cyc=%0d rd=%0d wid=%0d eop=%b required rd=%0d wid=%0d eop=1",
                  cyc, rd_out_16, wid_out_16, eop_16, e.rd, e.wid);
            end
         end
         if (valid_in_16 && ready_in_16) begin
            push_beats(16, f, w, rd);
            have_tile = 1'b0;
            accepted  = 1'b1;
         end
      end
      @(negedge clk);
      valid_in_16 = 1'b0; ready_out_16 = 1'b1;
      for (int c = 0; c < 4 && sb.size() > 0; c++) begin
         #1;
         if (valid_out_16) begin
            e = sb.pop_front();
            n_tests++;
            if (data_16 !== e.data || rd_out_16 !== e.rd || wid_out_16 !== e.wid) begin
               n_fail++; $display("FAIL stress_tail rd=%0d wid=%0d required %0d/%0d", rd_out_16, wid_out_16, e.rd, e.wid);
            end
         end
         @(negedge clk);
      end
      n_tests++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL stress_drain pending=%0d required 0", sb.size()); end
   endtask

   task automatic test_reset_mid_drain();
      logic [15:0][31:0] f, f2;
      exp_t e;
      for (int i = 0; i < 16; i++) begin f[i] = 32'h700 + i; f2[i] = 32'h800 + i; end
      sb.delete();
      push_beats(8, f, 4'd2, 4);
      @(negedge clk);
      tile_8 = to_tile(f); wid_8 = 4'd2; rd_8 = 5'd4; valid_in_8 = 1'b1; ready_out_8 = 1'b1;
      @(negedge clk); valid_in_8 = 1'b0; #1;
      e = sb.pop_front();
      n_tests++;
      if (valid_out_8 !== 1'b1 || data_8 !== e.data[7:0] || rd_out_8 !== e.rd || beat_8 !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_beat0 valid=%b data=%h rd=%0d beat=%0d required 1/%h/%0d/0",
            valid_out_8, data_8, rd_out_8, beat_8, e.data[7:0], e.rd);
      end
      @(negedge clk); ready_out_8 = 1'b0; #1;
      n_tests++;
      if (valid_out_8 !== 1'b1 || beat_8 !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_hold valid=%b beat=%0d required 1/1", valid_out_8, beat_8);
      end
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0; #1;
      sb.delete();
      n_tests++;
      if (valid_out_8 !== 1'b0 || busy_8 !== 1'b0 || ready_in_8 !== 1'b1 || stall_8 !== 32'd0) begin
         n_fail++; $display("FAIL rstmid_after valid=%b busy=%b ready_in=%b stall=%0d required 0/0/1/0",
            valid_out_8, busy_8, ready_in_8, stall_8);
      end
      push_beats(8, f2, 4'd6, 1);
      @(negedge clk);
      tile_8 = to_tile(f2); wid_8 = 4'd6; rd_8 = 5'd1; valid_in_8 = 1'b1; ready_out_8 = 1'b1;
      @(negedge clk); valid_in_8 = 1'b0; #1;
      for (int c = 0; c < 4 && sb.size() > 0; c++) begin
         if (valid_out_8) begin
            e = sb.pop_front();
            n_tests++;
            if (data_8 !== e.data[7:0] || rd_out_8 !== e.rd || wid_out_8 !== e.wid ||
                {1'b0, beat_8} !== e.beat || eop_8 !== e.eop) begin
               n_fail++; $display("FAIL rstmid_new data=%h rd=%0d wid=%0d beat=%0d eop=%b required %h/%0d/%0d/%0d/%b",
                  data_8, rd_out_8, wid_out_8, beat_8, eop_8, e.data[7:0], e.rd, e.wid, e.beat, e.eop);
            end
         end
         @(negedge clk); #1;
      end
      n_tests++;
      if (sb.size() != 0 || valid_out_8 !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_drain pending=%0d valid=%b required 0/0", sb.size(), valid_out_8);
      end
   endtask

   initial begin
      valid_in_4 = 1'b0; ready_out_4 = 1'b0; tile_4 = '0; wid_4 = '0; rd_4 = '0;
      valid_in_8 = 1'b0; ready_out_8 = 1'b0; tile_8 = '0; wid_8 = '0; rd_8 = '0;
      valid_in_16 = 1'b0; ready_out_16 = 1'b0; tile_16 = '0; wid_16 = '0; rd_16 = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      test_reset();
      test_single_tile();
      test_stall();
      test_back_to_back();
      test_rd_wrap();
      test_single_beat();
      test_random_stress();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
